// File: rtl/spi_req_arbiter.sv
// Round-robin arbiter that serialises NREQ requesters onto a single SPI master.
// One transaction outstanding at a time; completion may be forced by a timeout.
module spi_req_arbiter #(
    parameter int unsigned NREQ    = 4,
    parameter int unsigned AWIDTH  = 16,
    parameter int unsigned DWIDTH  = 8,
    parameter logic [31:0] TIMEOUT = 32'd4096
) (
    input  logic                     user_clk,
    input  logic                     user_rst_n,
    input  logic [NREQ-1:0]          i_req,
    input  logic [NREQ-1:0]          i_rw,
    input  logic [NREQ*AWIDTH-1:0]   i_addr,
    input  logic [NREQ*DWIDTH-1:0]   i_wdata,
    output logic [NREQ-1:0]          o_ack,
    output logic [NREQ-1:0]          o_done,
    output logic [DWIDTH-1:0]        o_rd_data,
    output logic                     o_timeout,
    output logic                     o_busy,
    output logic                     o_spi_rd_evt,
    output logic                     o_spi_wr_evt,
    output logic [AWIDTH-1:0]        o_spi_addr,
    output logic [DWIDTH-1:0]        o_spi_wr_data,
    input  logic                     i_spi_done_evt,
    input  logic                     i_spi_rd_evt,
    input  logic [DWIDTH-1:0]        i_spi_rd_data
);

    localparam int unsigned OW = $clog2(NREQ);

    typedef enum logic [2:0] {IDLE, ISSUE, WAIT_DONE, WAIT_RD, COMPLETE} state_t;

    state_t              state_q, state_d;
    logic [OW-1:0]       owner_q, owner_d;
    logic [OW-1:0]       last_q, last_d;
    logic                rw_q, rw_d;
    logic                tmo_q, tmo_d;
    logic [31:0]         cnt_q, cnt_d;
    logic [NREQ-1:0]     ack_q, ack_d;
    logic [NREQ-1:0]     done_q, done_d;
    logic [DWIDTH-1:0]   rd_data_q, rd_data_d;
    logic                timeout_q, timeout_d;
    logic                busy_q, busy_d;
    logic                rd_evt_q, rd_evt_d;
    logic                wr_evt_q, wr_evt_d;
    logic [AWIDTH-1:0]   addr_q, addr_d;
    logic [DWIDTH-1:0]   wdata_q, wdata_d;

    logic                grant_found;
    logic [OW-1:0]       grant_idx;
    logic [AWIDTH-1:0]   addr_sel;
    logic [DWIDTH-1:0]   wdata_sel;
    logic [31:0]         cand;

    // Search starts one past the previous owner so every requester gets a turn.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = '0;
        for (int unsigned i = 1; i <= NREQ; i++) begin
            cand = (32'(last_q) + i) % NREQ;
            if (!grant_found && i_req[OW'(cand)]) begin
                grant_found = 1'b1;
                grant_idx   = OW'(cand);
            end
        end
        addr_sel  = '0;
        wdata_sel = '0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            if (grant_idx == OW'(k)) begin
                addr_sel  = i_addr[k*AWIDTH +: AWIDTH];
                wdata_sel = i_wdata[k*DWIDTH +: DWIDTH];
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        last_d    = last_q;
        rw_d      = rw_q;
        tmo_d     = tmo_q;
        cnt_d     = cnt_q;
        ack_d     = '0;
        done_d    = '0;
        timeout_d = 1'b0;
        rd_evt_d  = 1'b0;
        wr_evt_d  = 1'b0;
        rd_data_d = rd_data_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;

        case (state_q)
            IDLE: begin
                if (grant_found) begin
                    owner_d          = grant_idx;
                    rw_d             = i_rw[grant_idx];
                    addr_d           = addr_sel;
                    wdata_d          = wdata_sel;
                    tmo_d            = 1'b0;
                    ack_d[grant_idx] = 1'b1;
                    state_d          = ISSUE;
                end
            end
            ISSUE: begin
                rd_evt_d = rw_q;
                wr_evt_d = !rw_q;
                cnt_d    = '0;
                state_d  = WAIT_DONE;
            end
            WAIT_DONE: begin
                cnt_d = cnt_q + 32'd1;
                if (i_spi_done_evt) begin
                    if (!rw_q) begin
                        state_d = COMPLETE;
                    end else if (i_spi_rd_evt) begin
                        rd_data_d = i_spi_rd_data;
                        state_d   = COMPLETE;
                    end else begin
                        state_d = WAIT_RD;
                    end
                end else if (cnt_q == TIMEOUT - 32'd1) begin
                    tmo_d   = 1'b1;
                    state_d = COMPLETE;
                end
            end
            WAIT_RD: begin
                cnt_d = cnt_q + 32'd1;
                if (i_spi_rd_evt) begin
                    rd_data_d = i_spi_rd_data;
                    state_d   = COMPLETE;
                end else if (cnt_q == TIMEOUT - 32'd1) begin
                    tmo_d   = 1'b1;
                    state_d = COMPLETE;
                end
            end
            COMPLETE: begin
                last_d  = owner_q;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // Done/timeout are registered on entry so they coincide with COMPLETE.
        if (state_d == COMPLETE && state_q != COMPLETE) begin
            done_d[owner_q] = 1'b1;
            timeout_d       = tmo_d;
        end
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge user_clk or negedge user_rst_n) begin
        if (!user_rst_n) begin
            state_q   <= IDLE;
            owner_q   <= '0;
            last_q    <= OW'(NREQ - 1);
            rw_q      <= 1'b0;
            tmo_q     <= 1'b0;
            cnt_q     <= '0;
            ack_q     <= '0;
            done_q    <= '0;
            rd_data_q <= '0;
            timeout_q <= 1'b0;
            busy_q    <= 1'b0;
            rd_evt_q  <= 1'b0;
            wr_evt_q  <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            last_q    <= last_d;
            rw_q      <= rw_d;
            tmo_q     <= tmo_d;
            cnt_q     <= cnt_d;
            ack_q     <= ack_d;
            done_q    <= done_d;
            rd_data_q <= rd_data_d;
            timeout_q <= timeout_d;
            busy_q    <= busy_d;
            rd_evt_q  <= rd_evt_d;
            wr_evt_q  <= wr_evt_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
        end
    end

    assign o_ack         = ack_q;
    assign o_done        = done_q;
    assign o_rd_data     = rd_data_q;
    assign o_timeout     = timeout_q;
    assign o_busy        = busy_q;
    assign o_spi_rd_evt  = rd_evt_q;
    assign o_spi_wr_evt  = wr_evt_q;
    assign o_spi_addr    = addr_q;
    assign o_spi_wr_data = wdata_q;

endmodule

// File: doc/spi_req_arbiter.md
SPI_REQ_ARBITER -- requirements
Module: spi_req_arbiter

Interface
REQ-001 SHALL have parameter NREQ, default 4, number of requesters (2..8).
REQ-002 SHALL have parameter AWIDTH, default 16, SPI address width.
REQ-003 SHALL have parameter DWIDTH, default 8, SPI data width.
REQ-004 SHALL have parameter TIMEOUT, default 32'd4096, maximum cycles waited for SPI completion.
REQ-005 SHALL have port user_clk  input  1  single clock; all logic on its rising edge.
REQ-006 SHALL have port user_rst_n  input  1  asynchronous active-low reset.
REQ-007 SHALL have port i_req  input  NREQ  per-requester request level.
REQ-008 SHALL have port i_rw  input  NREQ  per-requester type; 1 read, 0 write.
REQ-009 SHALL have port i_addr  input  NREQ*AWIDTH  requester k address at bits [k*AWIDTH +: AWIDTH].
REQ-010 SHALL have port i_wdata  input  NREQ*DWIDTH  requester k write data at bits [k*DWIDTH +: DWIDTH].
REQ-011 SHALL have port o_ack  output  NREQ  one-hot one-cycle pulse; request accepted.
REQ-012 SHALL have port o_done  output  NREQ  one-hot one-cycle pulse; transaction finished.
REQ-013 SHALL have port o_rd_data  output  DWIDTH  last read data.
REQ-014 SHALL have port o_timeout  output  1  pulse coincident with o_done when completion timed out.
REQ-015 SHALL have port o_busy  output  1  high in any state other than IDLE.
REQ-016 SHALL have ports o_spi_rd_evt, o_spi_wr_evt  output  1 each  one-cycle start pulses to the SPI master.
REQ-017 SHALL have ports o_spi_addr  output  AWIDTH and o_spi_wr_data  output  DWIDTH  latched transaction fields.
REQ-018 SHALL have ports i_spi_done_evt, i_spi_rd_evt  input  1 each, and i_spi_rd_data  input  DWIDTH, from the SPI master.

Function
REQ-019 SHALL implement states IDLE, ISSUE, WAIT_DONE, WAIT_RD, COMPLETE; all outputs registered.
REQ-020 IDLE with any i_req bit set SHALL select the winner round-robin, starting at (last_owner+1) mod NREQ, latch its rw/addr/wdata and owner index, pulse o_ack[owner] next cycle, and enter ISSUE.
REQ-021 ISSUE SHALL pulse exactly one of o_spi_rd_evt/o_spi_wr_evt for one cycle, per latched rw, then enter WAIT_DONE; o_spi_addr/o_spi_wr_data stable from ISSUE until return to IDLE.
REQ-022 WAIT_DONE on i_spi_done_evt SHALL go to COMPLETE for write, WAIT_RD for read; if i_spi_rd_evt arrives in the same cycle, it is captured and the read goes directly to COMPLETE.
REQ-023 WAIT_RD on i_spi_rd_evt SHALL capture i_spi_rd_data into o_rd_data and enter COMPLETE; i_spi_rd_evt outside WAIT_DONE/WAIT_RD is ignored.
REQ-024 A 32-bit timeout counter SHALL clear on entry to WAIT_DONE, count in WAIT_DONE and WAIT_RD, and on reaching TIMEOUT-1 force COMPLETE with timeout flag set; o_rd_data unchanged on timeout.
REQ-025 COMPLETE SHALL pulse o_done[owner] and, if flagged, o_timeout, for one cycle; last_owner updates to owner; return to IDLE.
REQ-026 Latency: i_req sampled in IDLE at cycle N -> o_ack at N+1, SPI start pulse at N+2; o_done one cycle after the completing event.
REQ-027 Requesters SHALL hold i_req and fields until o_ack; i_req dropped before ack means withdrawn, no transaction; i_req seen after COMPLETE is a new request.
REQ-028 At most one transaction SHALL be outstanding; requests arriving while busy wait, none are lost or reordered per requester.
REQ-029 Arbitration SHALL be starvation-free: a continuously requesting requester is served within NREQ transactions.

Reset
REQ-030 user_rst_n low SHALL immediately force IDLE, last_owner=NREQ-1 (requester 0 first), counter=0, all outputs 0; mid-transaction reset aborts with no o_done.

Verification
REQ-031 Single write from req 2 (addr 16'h0012, data 8'hA5): o_ack[2] at N+1, o_spi_wr_evt at N+2 with fields held; done_evt -> o_done[2] next cycle, o_timeout 0.
REQ-032 Read from req 0: done_evt, then rd_evt with data 8'h3C two cycles later -> o_rd_data=8'h3C, o_done[0] one cycle after rd_evt.
REQ-033 All four requesters held high continuously: grant order 0,1,2,3,0 with no repeats.
REQ-034 SPI never responds, TIMEOUT=16: o_done and o_timeout pulse 16 cycles after entering WAIT_DONE; o_rd_data unchanged.
REQ-035 Reset asserted in WAIT_DONE: outputs 0 asynchronously, no o_done; after release, pending req 1 granted normally.
REQ-036 i_req[3] pulsed while busy then dropped before ack: no o_ack[3], no SPI pulse for it.
